// File: rtl/adpll_cfg_bank.sv
// ADPLL programming bank: pin-driven shadow writes, atomic commit to the
// active set inside the core's safe-update window, readback and sticky error.

module adpll_cfg_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic pin_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_i};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

module adpll_cfg_bank #(
    parameter int DW          = 5,
    parameter int NPARAM      = 6,
    parameter int SEL_W       = 3,
    parameter int NDIV_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 pgm,
    input  logic [SEL_W-1:0]     param_sel,
    input  logic [DW-1:0]        pgm_value,
    input  logic                 commit,
    input  logic                 upd_ok,
    input  logic [SEL_W-1:0]     rd_sel,
    input  logic                 rd_src,
    output logic [DW-1:0]        rd_data,
    output logic [NPARAM*DW-1:0] params,
    output logic                 wr_ack,
    output logic                 pending,
    output logic                 upd_done,
    output logic                 err
);

    localparam logic [SEL_W:0]  NP        = (SEL_W+1)'(NPARAM);
    localparam logic [DW-1:0]   NDIV_MASK = DW'((1 << NDIV_W) - 1);

    typedef enum logic {
        IDLE,
        ARMED
    } state_e;

    state_e                state_q, state_d;
    logic [NPARAM*DW-1:0]  shd_q, shd_d;
    logic [NPARAM*DW-1:0]  act_q, act_d;
    logic [DW-1:0]         rd_q, rd_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  pend_q, pend_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  pgm_rise;
    logic                  commit_rise;
    logic                  sel_ok;
    logic [DW-1:0]         wdata;

    adpll_cfg_sync #(
        .STAGES (SYNC_STAGES)
    ) u_pgm_sync (
        .clk    (clk),
        .clr    (clr),
        .pin_i  (pgm),
        .rise_o (pgm_rise)
    );

    adpll_cfg_sync #(
        .STAGES (SYNC_STAGES)
    ) u_commit_sync (
        .clk    (clk),
        .clr    (clr),
        .pin_i  (commit),
        .rise_o (commit_rise)
    );

    // Field 0 (ndiv) only carries NDIV_W meaningful bits.
    assign sel_ok = {1'b0, param_sel} < NP;
    assign wdata  = (param_sel == '0) ? (pgm_value & NDIV_MASK) : pgm_value;

    always_comb begin
        state_d  = state_q;
        shd_d    = shd_q;
        act_d    = act_q;
        wr_ack_d = 1'b0;
        pend_d   = pend_q;
        done_d   = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (pgm_rise) begin
                    if (sel_ok) begin
                        for (int i = 0; i < NPARAM; i++) begin
                            if (param_sel == SEL_W'(i)) begin
                                shd_d[i*DW +: DW] = wdata;
                            end
                        end
                        wr_ack_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // upd_ok is ignored here, even when it coincides with commit.
                if (commit_rise) begin
                    state_d = ARMED;
                    pend_d  = 1'b1;
                end
            end
            ARMED: begin
                if (pgm_rise) begin
                    err_d = 1'b1;
                end
                if (upd_ok) begin
                    act_d   = shd_q;
                    done_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_d = '0;
        if ({1'b0, rd_sel} < NP) begin
            for (int i = 0; i < NPARAM; i++) begin
                if (rd_sel == SEL_W'(i)) begin
                    rd_d = rd_src ? shd_q[i*DW +: DW] : act_q[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            shd_q    <= '0;
            act_q    <= '0;
            rd_q     <= '0;
            wr_ack_q <= 1'b0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shd_q    <= shd_d;
            act_q    <= act_d;
            rd_q     <= rd_d;
            wr_ack_q <= wr_ack_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rd_data  = rd_q;
    assign params   = act_q;
    assign wr_ack   = wr_ack_q;
    assign pending  = pend_q;
    assign upd_done = done_q;
    assign err      = err_q;

endmodule
